// File: rtl/char_line_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : char_line_feeder_if
//  Description : Byte-stream input and character-display output bundle.
//  Revision    : 1.0
// ============================================================================
interface char_line_feeder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       add_input;
    logic [6:0] char_code;
    logic       line_clear;
    logic [4:0] col_count;
    logic       busy;

    modport master (
        input  in_data, in_valid,
        output in_ready, add_input, char_code, line_clear, col_count, busy
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, add_input, char_code, line_clear, col_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/char_line_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : char_line_feeder
//  Description : ASCII byte stream to character-display strobe/clear protocol.
//  Revision    : 1.0
// ============================================================================
module char_line_feeder #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned HOLD_CYC   = 4,
    parameter int unsigned GAP_CYC    = 4,
    parameter int unsigned CLR_CYC    = 2,
    parameter int unsigned LINE_LEN   = 16,
    parameter int unsigned WRAP_CLEAR = 1
) (
    input  wire logic           clk_50,
    input  wire logic           reset_n,
    char_line_feeder_if.master  bus
);

    localparam int unsigned         c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]       c_DEPTH     = (c_AW+1)'(DEPTH);
    localparam logic [15:0]         c_HOLD_LAST = 16'(HOLD_CYC - 1);
    localparam logic [15:0]         c_GAP_LAST  = 16'(GAP_CYC - 1);
    localparam logic [15:0]         c_CLR_LAST  = 16'(CLR_CYC - 1);
    localparam logic [4:0]          c_LINE_LEN  = 5'(LINE_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DISPATCH = 3'd1,
        S_STROBE   = 3'd2,
        S_GAP      = 3'd3,
        S_CLEAR    = 3'd4,
        S_CGAP     = 3'd5
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    logic            r_full;
    logic [c_AW:0]   w_count_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;

    assign w_push  = bus.in_valid && !r_full;
    assign w_empty = (r_count == '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
        end
    end

    // ------------------------------------------------ head-of-FIFO decode
    logic [7:0] w_head;
    logic [6:0] w_code;
    logic       w_is_clear;

    always_comb begin
        w_head     = r_mem[r_rptr];
        w_code     = 7'd127;
        w_is_clear = 1'b0;
        if (w_head == 8'h20) begin
            w_code = 7'd0;
        end else if (w_head >= 8'h41 && w_head <= 8'h5A) begin
            w_code = 7'(w_head - 8'h40);
        end else if (w_head == 8'h21) begin
            w_code = 7'd27;
        end else if (w_head >= 8'h30 && w_head <= 8'h39) begin
            w_code = 7'(w_head - 8'd20);
        end else if (w_head >= 8'h61 && w_head <= 8'h7A) begin
            w_code = 7'(w_head - 8'd59);
        end else if (w_head == 8'h2B) begin
            w_code = 7'd64;
        end else if (w_head == 8'h2D) begin
            w_code = 7'd65;
        end else if (w_head == 8'h0A || w_head == 8'h0C) begin
            w_code     = 7'd0;
            w_is_clear = 1'b1;
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [6:0]  r_code;
    logic        r_is_clear;
    logic        r_pend;
    logic [4:0]  r_col;
    logic [6:0]  r_char_code;
    logic        r_add_input;
    logic        r_line_clear;
    logic        r_busy;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (r_is_clear) begin
                    w_next = S_CLEAR;
                end else if (r_col < c_LINE_LEN) begin
                    w_next = S_STROBE;
                end else if (WRAP_CLEAR != 0) begin
                    w_next = S_CLEAR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_STROBE: if (r_cnt == c_HOLD_LAST) w_next = S_GAP;
            S_GAP:    if (r_cnt == c_GAP_LAST)  w_next = S_IDLE;
            S_CLEAR:  if (r_cnt == c_CLR_LAST)  w_next = S_CGAP;
            S_CGAP:   if (r_cnt == c_GAP_LAST)  w_next = r_pend ? S_STROBE : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so each strobe/clear
    // lags its state by one cycle; spacing between pulses is preserved.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_code       <= '0;
            r_is_clear   <= 1'b0;
            r_pend       <= 1'b0;
            r_col        <= '0;
            r_char_code  <= '0;
            r_add_input  <= 1'b0;
            r_line_clear <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_cnt <= '0;
            else                   r_cnt <= r_cnt + 16'd1;

            if (w_pop) begin
                r_code     <= w_code;
                r_is_clear <= w_is_clear;
            end

            if (r_state == S_DISPATCH) begin
                if (!r_is_clear) r_char_code <= r_code;
                r_pend <= (w_next == S_CLEAR) && !r_is_clear;
            end else if (r_state == S_CGAP && w_next != S_CGAP) begin
                r_pend <= 1'b0;
            end

            if (r_state == S_STROBE && w_next == S_GAP) begin
                r_col <= r_col + 5'd1;
            end else if (r_state == S_DISPATCH && w_next == S_CLEAR) begin
                r_col <= '0;
            end

            r_add_input  <= (r_state == S_STROBE);
            r_line_clear <= (r_state == S_CLEAR);
            r_busy       <= (w_next != S_IDLE) || (w_count_nxt != '0);
        end
    end

    assign bus.in_ready   = !r_full;
    assign bus.add_input  = r_add_input;
    assign bus.char_code  = r_char_code;
    assign bus.line_clear = r_line_clear;
    assign bus.col_count  = r_col;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/char_line_feeder.md
Name: char_line_feeder

Overview:
- Producer side of the character-line display interface. Converts an ASCII byte stream into the display's character-code pulse protocol: one `add_input` level pulse per character, a 7-bit `char_code`, and a `line_clear` pulse wired to the display's line-buffer reset.
- Buffers input in a small FIFO and tracks the 16-slot line occupancy.
- Issues a clear automatically on overflow or when it receives a newline.
- Sits between the upstream text source (classifier/UART) and the VGA character display, in the `clk_50` domain.

Parameters:
- DEPTH, 8, input FIFO entries; power of 2, minimum 2.
- HOLD_CYC, 4, cycles `add_input` is held high per character; minimum 1.
- GAP_CYC, 4, cycles `add_input` is held low after each strobe or clear; minimum 1.
- CLR_CYC, 2, cycles `line_clear` is held high; minimum 1.
- LINE_LEN, 16, character slots per display line.
- WRAP_CLEAR, 1, 1 = auto-clear before the 17th printable character; 0 = drop the character instead.

Ports:
- clk_50  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  ASCII byte.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  FIFO not full; a byte transfers when `in_valid && in_ready` at a rising edge.
- add_input  out  1  character strobe to the display.
- char_code  out  7  display character code; stable whenever `add_input` is high.
- line_clear  out  1  active-high clear to the display line buffer.
- col_count  out  5  slots used on the current line, 0..LINE_LEN.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (asynchronous, reset_n low):
  - FIFO is emptied; state = IDLE.
  - add_input = 0, char_code = 0, line_clear = 0, col_count = 0, busy = 0.
  - in_ready = 1 once reset is released.
  - Reset asserted mid-strobe or mid-clear drops add_input and line_clear immediately; the pending character is discarded.
- Translation (combinational on the FIFO head; latched on pop):
  - ' ' → 0.
  - 'A'-'Z' → 1-26.
  - '!' → 27.
  - '0'-'9' → 28-37.
  - 'a'-'z' → 38-63.
  - '+' → 64; '-' → 65.
  - 0x0A and 0x0C → class CLEAR, with no code.
  - Any other byte → code 127 (the display's block glyph), class PRINT.
- FIFO:
  - in_ready = !full.
  - A push while full cannot occur.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO is non-empty, pop; latch the code and class; go to DISPATCH.
  - DISPATCH:
    - Class CLEAR → CLEAR, pending = 0.
    - PRINT with col_count < LINE_LEN → STROBE.
    - PRINT with col_count == LINE_LEN:
      - WRAP_CLEAR = 1 → CLEAR, pending = 1.
      - WRAP_CLEAR = 0 → IDLE; the character is dropped.
  - STROBE: add_input = 1 for HOLD_CYC cycles; char_code = latched code. On exit, col_count increments; go to GAP.
  - GAP: add_input = 0 for GAP_CYC cycles; then IDLE.
  - CLEAR: line_clear = 1 for CLR_CYC cycles; col_count := 0 on entry; then CGAP.
  - CGAP: add_input = 0 and line_clear = 0 for GAP_CYC cycles; then STROBE if pending, else IDLE. pending is cleared on leaving CGAP.
- Protocol guarantees:
  - add_input always returns low for at least GAP_CYC cycles between characters.
  - add_input and line_clear are never high together.
  - char_code changes only while add_input is low.
- Latency, FIFO empty and FSM in IDLE: a byte accepted at edge N gives add_input high after edge N+3 (push N, pop N+1, dispatch N+2, strobe N+3).
- Throughput: one character per HOLD_CYC + GAP_CYC + 2 cycles.
- All outputs are registered, and they hold their values while FIFO back-pressure is applied.

Test Plan:
1. Reset, then push "A", with HOLD=4 and GAP=4 → after edge N+3, add_input is high for exactly 4 cycles with char_code = 1; then low for 4 cycles; col_count = 1; busy drops to 0.
2. Push "z9+-!? " back-to-back → char_code sequence 63, 37, 64, 65, 27, 127, 0. Each strobe is separated by ≥ 4 low cycles, and col_count = 7 at the end.
3. Hold in_valid with 12 bytes and no stall, DEPTH=8 → in_ready goes low when the FIFO is full; no byte is lost or duplicated; all 12 codes appear in order.
4. Push 17 'A's with WRAP_CLEAR=1 → 16 strobes; then line_clear is high for 2 cycles; col_count = 0; then the 17th strobe (code 1); col_count = 1. Repeat with WRAP_CLEAR=0 → no clear, the 17th character is dropped, col_count stays 16.
5. Push "AB", 0x0A, "C" → 2 strobes; line_clear pulse; col_count = 0; 1 strobe; final col_count = 1.
6. Assert reset_n low during the second HOLD cycle of a strobe with 3 bytes queued → add_input falls asynchronously; after release, FIFO is empty, col_count = 0, no further strobes.
